// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern mode encoding and bar colour table
// for the VGA timing generator.
package vga_pkg;

    localparam int DEF_HRES    = 640;
    localparam int DEF_HFP     = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBP     = 48;
    localparam int DEF_VRES    = 480;
    localparam int DEF_VFP     = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBP     = 33;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2
    } mode_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // The reserved encoding falls back to passthrough.
    function automatic mode_t decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_PASS : mode_t'(m);
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: eight vertical colour bars, a checkerboard, or the
// external pixel passed through. Output is zero outside the active area.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int HRES = DEF_HRES,
    parameter int XW   = 10,
    parameter int YW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          active,
    input  logic          line_start,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    mode_q,
    input  logic [23:0]   rgb_in,
    output logic [23:0]   rgb
);

    localparam int BAR_W = HRES / 8;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);
    // Checker square size is 16 pixels; narrower counters use their MSB.
    localparam int XB = (XW >= 5) ? 4 : XW - 1;
    localparam int YB = (YW >= 5) ? 4 : YW - 1;

    logic [BPW-1:0] bar_pix;
    logic [2:0]     bar_idx;
    logic           chk_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (line_start) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (pix_en && active) begin
            if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + BPW'(1);
            end
        end
    end

    assign chk_on = (|((x >> XB) & XW'(1))) ^ (|((y >> YB) & YW'(1)));

    always_comb begin
        rgb = '0;
        if (active) begin
            case (mode_t'(mode_q))
                MODE_BARS:  rgb = bar_colour(bar_idx);
                MODE_CHECK: rgb = chk_on ? 24'hFFFFFF : 24'h000000;
                default:    rgb = rgb_in;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing engine: pixel-clock divider, h/v counters, sync
// decode, mode latching and a registered DAC output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HRES      = DEF_HRES,
    parameter int HFP       = DEF_HFP,
    parameter int HSYNC     = DEF_HSYNC,
    parameter int HBP       = DEF_HBP,
    parameter int VRES      = DEF_VRES,
    parameter int VFP       = DEF_VFP,
    parameter int VSYNC     = DEF_VSYNC,
    parameter int VBP       = DEF_VBP,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    localparam int HTOTAL   = HRES + HFP + HSYNC + HBP,
    localparam int VTOTAL   = VRES + VFP + VSYNC + VBP,
    localparam int XW       = $clog2(HTOTAL),
    localparam int YW       = $clog2(VTOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [7:0]    r_in,
    input  logic [7:0]    g_in,
    input  logic [7:0]    b_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          pix_en,
    output logic          line_start,
    output logic          frame_start,
    output logic          vgaclk,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [XW-1:0] H_LAST   = XW'(HTOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(VTOTAL - 1);
    // One extra bit so decode bounds equal to the total never wrap.
    localparam logic [XW:0]   H_ACT    = (XW+1)'(HRES);
    localparam logic [XW:0]   HS_BEG   = (XW+1)'(HRES + HFP);
    localparam logic [XW:0]   HS_END   = (XW+1)'(HRES + HFP + HSYNC);
    localparam logic [YW:0]   V_ACT    = (YW+1)'(VRES);
    localparam logic [YW:0]   VS_BEG   = (YW+1)'(VRES + VFP);
    localparam logic [YW:0]   VS_END   = (YW+1)'(VRES + VFP + VSYNC);
    localparam logic          HS_ON    = (HSYNC_POL != 0);
    localparam logic          VS_ON    = (VSYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [XW-1:0] hcnt;
    logic [YW-1:0] vcnt;
    logic [1:0]    mode_q;
    logic          hs_raw;
    logic          vs_raw;
    logic [23:0]   pat_rgb;

    assign pix_en  = (div_cnt == DIV_LAST);
    assign div_nxt = pix_en ? '0 : div_cnt + DW'(1);

    // vgaclk follows the divider phase so its rising edge lands mid-pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            vgaclk  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            vgaclk  <= (div_nxt >= DIV_HALF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + YW'(1);
            end else begin
                hcnt <= hcnt + XW'(1);
            end
        end
    end

    assign x           = hcnt;
    assign y           = vcnt;
    assign active      = ({1'b0, hcnt} < H_ACT) && ({1'b0, vcnt} < V_ACT);
    assign line_start  = pix_en && (hcnt == H_LAST);
    assign frame_start = line_start && (vcnt == V_LAST);
    assign hs_raw      = ({1'b0, hcnt} >= HS_BEG) && ({1'b0, hcnt} < HS_END);
    assign vs_raw      = ({1'b0, vcnt} >= VS_BEG) && ({1'b0, vcnt} < VS_END);
    assign sync_b      = 1'b0;

    // Mode only changes at a frame boundary so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_PASS;
        end else if (frame_start) begin
            mode_q <= decode_mode(mode);
        end
    end

    vga_pattern_gen #(
        .HRES (HRES),
        .XW   (XW),
        .YW   (YW)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .active     (active),
        .line_start (line_start),
        .x          (hcnt),
        .y          (vcnt),
        .mode_q     (mode_q),
        .rgb_in     ({r_in, g_in, b_in}),
        .rgb        (pat_rgb)
    );

    // Output stage: one pixel period behind x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync   <= ~HS_ON;
            vsync   <= ~VS_ON;
            blank_b <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else if (pix_en) begin
            hsync     <= hs_raw ? HS_ON : ~HS_ON;
            vsync     <= vs_raw ? VS_ON : ~VS_ON;
            blank_b   <= active;
            {r, g, b} <= pat_rgb;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in the 8x4 small configuration: a clock-count
// reference model predicts every output each cycle under random pixel data.
module tb_vga_timing_gen;

    localparam int HRES = 8, HFP = 2, HSYNC = 3, HBP = 1;
    localparam int VRES = 4, VFP = 1, VSYNC = 1, VBP = 1;
    localparam int D  = 2;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] r_in, g_in, b_in;

    logic [3:0] x0, x1;
    logic [2:0] y0, y1;
    logic       act0, pe0, ls0, fs0, vc0, hs0, vs0, sb0, bl0;
    logic       act1, pe1, ls1, fs1, vc1, hs1, vs1, sb1, bl1;
    logic [7:0] r0, g0, b0, r1, g1, b1;

    int          tests = 0;
    int          fails = 0;
    int          n;
    int          frame_mode [16];
    logic [23:0] last_in;
    logic [23:0] pend;
    logic        pend_v;
    int          guard;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .CLK_DIV(D), .HSYNC_POL(0), .VSYNC_POL(0)
    ) u0 (
        .clk(clk), .rst(rst), .mode(mode), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x0), .y(y0), .active(act0), .pix_en(pe0), .line_start(ls0),
        .frame_start(fs0), .vgaclk(vc0), .hsync(hs0), .vsync(vs0), .sync_b(sb0),
        .blank_b(bl0), .r(r0), .g(g0), .b(b0)
    );

    vga_timing_gen #(
        .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .CLK_DIV(D), .HSYNC_POL(1), .VSYNC_POL(1)
    ) u1 (
        .clk(clk), .rst(rst), .mode(mode), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x1), .y(y1), .active(act1), .pix_en(pe1), .line_start(ls1),
        .frame_start(fs1), .vgaclk(vc1), .hsync(hs1), .vsync(vs1), .sync_b(sb1),
        .blank_b(bl1), .r(r1), .g(g1), .b(b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (clk %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [23:0] bar_col(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // x is 4 bits and y is 3 bits here, so the checker uses bits 3 and 2.
    function automatic logic [23:0] pattern(input int m, input int hq, input int vq);
        case (m)
            1: return bar_col(hq / (HRES / 8));
            2: return ((((hq >> 3) ^ (vq >> 2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return last_in;
        endcase
    endfunction

    task automatic check_all();
        int dv, p, h, v, q, hq, vq, f;
        logic e_pe, e_ls, e_fs, e_vc, e_act, e_hs, e_vs, e_bl;
        logic [23:0] e_rgb;
        dv = n % D; p = n / D; h = p % HT; v = (p / HT) % VT;
        e_pe  = (dv == D - 1);
        e_ls  = e_pe && (h == HT - 1);
        e_fs  = e_ls && (v == VT - 1);
        e_vc  = (dv >= D / 2);
        e_act = (h < HRES) && (v < VRES);
        e_hs = 1'b0; e_vs = 1'b0; e_bl = 1'b0; e_rgb = 24'h0;
        if (p > 0) begin
            q = p - 1; hq = q % HT; vq = (q / HT) % VT; f = q / FR;
            e_hs = (hq >= HRES + HFP) && (hq < HRES + HFP + HSYNC);
            e_vs = (vq >= VRES + VFP) && (vq < VRES + VFP + VSYNC);
            e_bl = (hq < HRES) && (vq < VRES);
            if (e_bl) e_rgb = pattern(frame_mode[f], hq, vq);
        end
        chk("x",           32'(x0),   32'(h));
        chk("y",           32'(y0),   32'(v));
        chk("active",      32'(act0), 32'(e_act));
        chk("pix_en",      32'(pe0),  32'(e_pe));
        chk("line_start",  32'(ls0),  32'(e_ls));
        chk("frame_start", 32'(fs0),  32'(e_fs));
        chk("vgaclk",      32'(vc0),  32'(e_vc));
        chk("hsync",       32'(hs0),  32'(!e_hs));
        chk("vsync",       32'(vs0),  32'(!e_vs));
        chk("sync_b",      32'(sb0),  32'(0));
        chk("blank_b",     32'(bl0),  32'(e_bl));
        chk("rgb",         32'({r0, g0, b0}), 32'(e_rgb));
        chk("pol1_x",      32'({y1, x1}), 32'({v[2:0], h[3:0]}));
        chk("pol1_strobes", 32'({act1, pe1, ls1, fs1, vc1, sb1}),
            32'({e_act, e_pe, e_ls, e_fs, e_vc, 1'b0}));
        chk("pol1_hsync",  32'(hs1),  32'(e_hs));
        chk("pol1_vsync",  32'(vs1),  32'(e_vs));
        chk("pol1_video",  32'({bl1, r1, g1, b1}), 32'({e_bl, e_rgb}));
    endtask

    task automatic mode_ctl();
        int p, f, pos;
        p = n / D; f = p / FR; pos = p % FR;
        if (n % D == 0 && pos == FR / 2) begin
            case (f)
                0: mode = 2'd1;
                1: mode = 2'd2;
                2: mode = 2'd3;
                default: mode = 2'($urandom_range(0, 3));
            endcase
        end
        // Change landing on the frame_start clock itself.
        if (f == 3 && pos == FR - 1 && n % D == D - 1) mode = 2'd1;
    endtask

    task automatic step();
        int p;
        p = n / D;
        r_in = 8'(p % HT);
        g_in = 8'((p / HT) % VT);
        if (n % D == 0) b_in = 8'($urandom);
        pend_v = (n % D == D - 1);
        pend   = {r_in, g_in, b_in};
        @(posedge clk);
        n++;
        if (pend_v) last_in = pend;
        if (n % D == 0 && (n / D) % FR == 0)
            frame_mode[(n / D) / FR] = (mode == 2'd3) ? 0 : int'(mode);
        @(negedge clk);
    endtask

    task automatic cycle();
        check_all();
        mode_ctl();
        step();
    endtask

    task automatic model_reset();
        n = 0;
        last_in = 24'h0;
        for (int i = 0; i < 16; i++) frame_mode[i] = 0;
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; r_in = 8'h0; g_in = 8'h0; b_in = 8'h5A;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 6 * FR * D; i++) cycle();

        guard = 0;
        while (!(((n / D) % HT == 5) && (((n / D) / HT) % VT == 2)) && guard < FR * D) begin
            cycle();
            guard++;
        end
        chk("reach_h5_v2", 32'(guard < FR * D), 32'(1));

        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 2 * FR * D + 20; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
